rgb_pwm_sched: RTL and testbench
================================

RGB_PWM_SCHED -- requirements
Module: rgb_pwm_sched

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, PWM period in clk cycles and full-scale duty value.
REQ-002 SHALL have parameter DIM_SHIFT, default 2, right-shift applied to duties in DIM mode.
REQ-003 SHALL define DW = $clog2(PWM_INTERVAL), 11 at defaults; all duty ports are DW bits wide.
REQ-004 SHALL have port clk  input  1  sole clock, 12 MHz, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port btn  input  1  single-cycle mode-advance pulse, synchronous to clk.
REQ-007 SHALL have ports r_duty, g_duty, b_duty  input  DW  requested duty per channel, from the colour-wheel generator.
REQ-008 SHALL have ports red, green, blue  output  1  registered PWM drive per channel.
REQ-009 SHALL have port mode  output  2  current mode: 00 RUN, 01 FREEZE, 10 DIM, 11 OFF.
REQ-010 SHALL have port period_start  output  1  registered one-cycle pulse in the first cycle of each PWM period.

Function
REQ-011 SHALL keep one shared period counter cnt, 0..PWM_INTERVAL-1, incrementing every cycle and wrapping to 0 after PWM_INTERVAL-1.
REQ-012 SHALL hold three shadow duty registers; channel outputs derive only from shadows, never directly from duty inputs.
REQ-013 SHALL load shadows only in the cycle where cnt == PWM_INTERVAL-1 (period boundary), so duty changes never glitch mid-period.
REQ-014 SHALL load at boundary per the registered mode: RUN -> duty input; FREEZE -> unchanged; DIM -> duty input >> DIM_SHIFT; OFF -> 0.
REQ-015 SHALL clamp any duty input >= PWM_INTERVAL to PWM_INTERVAL before shift/load.
REQ-016 SHALL register each channel as (cnt < shadow), giving exactly shadow high cycles per period, one-cycle latency from cnt.
REQ-017 SHALL give shadow 0 -> output never active; shadow PWM_INTERVAL -> output active for the whole period.
REQ-018 SHALL assert period_start exactly when cnt == 0, one cycle per PWM_INTERVAL cycles.
REQ-019 SHALL advance mode on each btn-high cycle: RUN -> FREEZE -> DIM -> OFF -> RUN; the new mode is visible on the mode port the next cycle.
REQ-020 SHALL, when btn and boundary coincide, load shadows using the pre-advance mode; the new mode takes effect at the following boundary.
REQ-021 SHALL advance mode once per cycle when btn is held high over consecutive cycles; no internal debounce.

Reset
REQ-022 SHALL, while rst is high, force cnt = 0, mode = RUN, shadows = 0, period_start = 0, and red/green/blue at their inactive level, independent of clk.
REQ-023 SHALL, after rst deasserts, start counting from cnt = 0 on the first rising edge, with period_start asserted in that first cycle.
REQ-024 SHALL abandon any partial period on mid-operation reset; no shadow value survives reset.

Configuration
REQ-025 SHALL support macro LED_ACTIVE_LOW_EN: when defined, red/green/blue are inverted (active = 0, inactive = 1, reset level 1), matching the sinking on-chip RGB driver; when undefined, active = 1, inactive = 0, reset level 0. Counting, mode and period_start behaviour are identical in both builds.

Verification
REQ-026 SHALL cover: reset, r_duty=600, g_duty=0, b_duty=1200 held in RUN -> from the second period on, red high 600 of 1200 cycles, green never high, blue always high; period_start every 1200 cycles.
REQ-027 SHALL cover: r_duty changes 300->900 at cnt=500 -> red stays at 300-cycle width for the current period, 900-cycle width from the next period.
REQ-028 SHALL cover: btn pulse in RUN -> mode=01 next cycle; r_duty then changes to 100 -> red width keeps its previous value indefinitely.
REQ-029 SHALL cover: DIM mode with r_duty=1000 -> red high 250 cycles per period; r_duty=2047 -> clamped, red high 300 cycles.
REQ-030 SHALL cover: btn asserted in the cycle with cnt=1199 while in RUN -> that boundary loads raw duties, mode=01, next boundary holds; also rst pulsed at cnt=700 -> outputs inactive immediately, mode=00, cnt restarts at 0; both LED_ACTIVE_LOW_EN builds run.

Source files
------------

// File: rtl/rgb_pwm_sched.sv
// Three-channel LED PWM with period-aligned shadow duties and a 4-mode button cycle.
// Optional LED_ACTIVE_LOW_EN inverts the red/green/blue pin levels for sinking drivers.
module rgb_pwm_sched #(
    parameter int PWM_INTERVAL = 1200,
    parameter int DIM_SHIFT    = 2,
    localparam int DW          = $clog2(PWM_INTERVAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn,
    input  logic [DW-1:0] r_duty,
    input  logic [DW-1:0] g_duty,
    input  logic [DW-1:0] b_duty,
    output logic          red,
    output logic          green,
    output logic          blue,
    output logic [1:0]    mode,
    output logic          period_start
);

    // Shadows must hold the full-scale value PWM_INTERVAL itself.
    localparam int SW = $clog2(PWM_INTERVAL + 1);
    localparam logic [DW-1:0] LAST = DW'(PWM_INTERVAL - 1);
    localparam logic [SW-1:0] FULL = SW'(PWM_INTERVAL);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_ON = 1'b0;
`else
    localparam logic LED_ON = 1'b1;
`endif
    localparam logic LED_OFF = ~LED_ON;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        FREEZE = 2'b01,
        DIM    = 2'b10,
        OFF    = 2'b11
    } mode_e;

    mode_e         mode_q, mode_d;
    logic          run_q, run_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] r_sh_q, r_sh_d;
    logic [SW-1:0] g_sh_q, g_sh_d;
    logic [SW-1:0] b_sh_q, b_sh_d;
    logic          red_q, red_d;
    logic          green_q, green_d;
    logic          blue_q, blue_d;
    logic          pstart_q, pstart_d;
    logic          boundary;

    function automatic logic [SW-1:0] clamp(input logic [DW-1:0] d);
        if (SW'(d) >= FULL) begin
            return FULL;
        end
        return SW'(d);
    endfunction

    function automatic logic [SW-1:0] load(
        input mode_e         m,
        input logic [DW-1:0] d,
        input logic [SW-1:0] cur
    );
        logic [SW-1:0] v;
        v = cur;
        unique case (m)
            RUN:    v = clamp(d);
            FREEZE: v = cur;
            DIM:    v = clamp(d) >> DIM_SHIFT;
            OFF:    v = '0;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= RUN;
            run_q    <= 1'b0;
            cnt_q    <= '0;
            r_sh_q   <= '0;
            g_sh_q   <= '0;
            b_sh_q   <= '0;
            red_q    <= LED_OFF;
            green_q  <= LED_OFF;
            blue_q   <= LED_OFF;
            pstart_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            r_sh_q   <= r_sh_d;
            g_sh_q   <= g_sh_d;
            b_sh_q   <= b_sh_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            pstart_q <= pstart_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (btn) begin
            unique case (mode_q)
                RUN:    mode_d = FREEZE;
                FREEZE: mode_d = DIM;
                DIM:    mode_d = OFF;
                OFF:    mode_d = RUN;
            endcase
        end
    end

    // The first edge after reset re-enters cnt = 0 so that cycle opens a period.
    always_comb begin
        run_d    = 1'b1;
        cnt_d    = '0;
        boundary = 1'b0;
        if (run_q) begin
            boundary = (cnt_q == LAST);
            cnt_d    = boundary ? '0 : cnt_q + DW'(1);
        end
        pstart_d = (cnt_d == '0);
    end

    always_comb begin
        r_sh_d = r_sh_q;
        g_sh_d = g_sh_q;
        b_sh_d = b_sh_q;
        if (boundary) begin
            r_sh_d = load(mode_q, r_duty, r_sh_q);
            g_sh_d = load(mode_q, g_duty, g_sh_q);
            b_sh_d = load(mode_q, b_duty, b_sh_q);
        end
    end

    always_comb begin
        red_d   = (SW'(cnt_q) < r_sh_q) ? LED_ON : LED_OFF;
        green_d = (SW'(cnt_q) < g_sh_q) ? LED_ON : LED_OFF;
        blue_d  = (SW'(cnt_q) < b_sh_q) ? LED_ON : LED_OFF;
    end

    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;
    assign mode         = mode_q;
    assign period_start = pstart_q;

endmodule

// File: tb/tb_rgb_pwm_sched.sv
// Directed bench for rgb_pwm_sched: widths per period, mode cycling, boundary and reset cases.
module tb_rgb_pwm_sched;

    localparam int P  = 1200;
    localparam int DW = 11;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic ON = 1'b0;
`else
    localparam logic ON = 1'b1;
`endif
    localparam logic OFFL = ~ON;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn = 1'b0;
    logic [DW-1:0] r_duty = '0;
    logic [DW-1:0] g_duty = '0;
    logic [DW-1:0] b_duty = '0;
    logic          red, green, blue, period_start;
    logic [1:0]    mode;

    int checks = 0;
    int errors = 0;
    int rc, gc, bc, pc;

    rgb_pwm_sched #(.PWM_INTERVAL(P), .DIM_SHIFT(2)) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .r_duty(r_duty),
        .g_duty(g_duty),
        .b_duty(b_duty),
        .red(red),
        .green(green),
        .blue(blue),
        .mode(mode),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic count_window(input int chg_at, input logic [DW-1:0] chg_val);
        rc = 0; gc = 0; bc = 0; pc = 0;
        for (int i = 1; i <= P; i++) begin
            if (i - 1 == chg_at) r_duty = chg_val;
            @(negedge clk);
            if (red === ON) rc++;
            if (green === ON) gc++;
            if (blue === ON) bc++;
            if (period_start === 1'b1) pc++;
        end
    endtask

    task automatic measure(input int chg_at, input logic [DW-1:0] chg_val);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * P + 10; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            check("ps_wait", 0, 1);
            rc = -1; gc = -1; bc = -1; pc = -1;
        end else begin
            count_window(chg_at, chg_val);
        end
    endtask

    task automatic press();
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_ps", period_start, 0);
        check("rst_red", red, OFFL);
        check("rst_green", green, OFFL);
        check("rst_blue", blue, OFFL);

        r_duty = 11'd600;
        g_duty = 11'd0;
        b_duty = 11'd1200;
        rst = 1'b0;
        @(negedge clk);
        check("first_ps", period_start, 1);
        measure(-1, '0);
        check("run_red600", rc, 600);
        check("run_green0", gc, 0);
        check("run_blue1200", bc, 1200);
        check("run_ps_once", pc, 1);

        r_duty = 11'd300;
        measure(-1, '0);
        check("red300", rc, 300);
        measure(500, 11'd900);
        check("midchg_red300", rc, 300);
        measure(-1, '0);
        check("next_red900", rc, 900);

        press();
        check("mode_freeze", mode, 1);
        r_duty = 11'd100;
        measure(-1, '0);
        check("frz_red900_a", rc, 900);
        measure(-1, '0);
        check("frz_red900_b", rc, 900);

        press();
        check("mode_dim", mode, 2);
        r_duty = 11'd1000;
        measure(-1, '0);
        check("dim_red250", rc, 250);
        r_duty = 11'd2047;
        measure(-1, '0);
        check("dim_red_clamp300", rc, 300);
        check("dim_blue300", bc, 300);
        check("dim_green0", gc, 0);

        press();
        check("mode_off", mode, 3);
        measure(-1, '0);
        check("off_red0", rc, 0);
        check("off_blue0", bc, 0);
        press();
        check("mode_run", mode, 0);
        r_duty = 11'd800;
        measure(-1, '0);
        check("rerun_red800", rc, 800);

        r_duty = 11'd400;
        repeat (P - 1) @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        check("bnd_mode", mode, 1);
        check("bnd_ps", period_start, 1);
        count_window(-1, '0);
        check("bnd_red400", rc, 400);
        r_duty = 11'd50;
        measure(-1, '0);
        check("bnd_hold400", rc, 400);

        btn = 1'b1;
        @(negedge clk);
        check("held_dim", mode, 2);
        @(negedge clk);
        check("held_off", mode, 3);
        @(negedge clk);
        btn = 1'b0;
        check("held_run", mode, 0);

        r_duty = 11'd1000;
        measure(-1, '0);
        check("pre_rst_red1000", rc, 1000);
        repeat (700) @(negedge clk);
        check("cnt700_red_on", red, ON);
        press();
        check("pre_rst_mode", mode, 1);
        rst = 1'b1;
        #1;
        check("async_red", red, OFFL);
        check("async_blue", blue, OFFL);
        check("async_mode", mode, 0);
        check("async_ps", period_start, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_ps", period_start, 1);
        count_window(-1, '0);
        check("restart_red0", rc, 0);
        check("restart_blue0", bc, 0);
        check("restart_ps_once", pc, 1);
        measure(-1, '0);
        check("restart_red1000", rc, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
